memq_id_alloc: RTL

Allocates load-queue and store-queue IDs in program order for uops leaving the RA stage. Supplies `ldqid_alloc_rs0`/`stqid_alloc_rs0` and the `ldq_stall_rs0`/`stq_stall_rs0` back-pressure that alloc consumes. Tracks retirement and store drain, and rolls back speculative allocations on a nuke. Sits between alloc, the ROB retire path and the memory queues.

---
 rtl/memq_id_alloc_if.sv | 42 ++++
 rtl/memq_id_alloc.sv | 118 +++++++++++
 2 files changed

// File: rtl/memq_id_alloc_if.sv
// Handshake bundle between alloc, the ROB retire path and memq_id_alloc.
// Also holds the nuke packet type shared by both sides.
package memq_id_alloc_pkg;
    typedef struct packed {
        logic valid;
    } t_nuke_pkt;
endpackage

interface memq_id_alloc_if #(
    parameter int LDQ_DEPTH = 8,
    parameter int STQ_DEPTH = 8
);
    localparam int LW = $clog2(LDQ_DEPTH) + 1;
    localparam int SW = $clog2(STQ_DEPTH) + 1;

    typedef logic [LW-1:0] t_ldq_id;
    typedef logic [SW-1:0] t_stq_id;

    memq_id_alloc_pkg::t_nuke_pkt nuke_rb1;
    logic    disp_valid_rs0;
    logic    disp_is_ld_rs0;
    logic    disp_is_st_rs0;
    logic    ldq_retire_rb1;
    logic    stq_retire_rb1;
    logic    stq_drain_mm;
    t_ldq_id ldqid_alloc_rs0;
    t_stq_id stqid_alloc_rs0;
    logic    ldq_stall_rs0;
    logic    stq_stall_rs0;

    modport master (
        output nuke_rb1, disp_valid_rs0, disp_is_ld_rs0, disp_is_st_rs0,
               ldq_retire_rb1, stq_retire_rb1, stq_drain_mm,
        input  ldqid_alloc_rs0, stqid_alloc_rs0, ldq_stall_rs0, stq_stall_rs0
    );

    modport slave (
        input  nuke_rb1, disp_valid_rs0, disp_is_ld_rs0, disp_is_st_rs0,
               ldq_retire_rb1, stq_retire_rb1, stq_drain_mm,
        output ldqid_alloc_rs0, stqid_alloc_rs0, ldq_stall_rs0, stq_stall_rs0
    );
endinterface

// File: rtl/memq_id_alloc.sv
// In-order LDQ/STQ ID allocator with retire, drain and nuke rollback.
// Optional MEMQ_ID_ALLOC_SKID_EN reserves one entry of each queue for a skid uop.
module memq_id_alloc #(
    parameter int LDQ_DEPTH = 8,
    parameter int STQ_DEPTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    memq_id_alloc_if.slave bus
);
    localparam int LW = $clog2(LDQ_DEPTH) + 1;
    localparam int SW = $clog2(STQ_DEPTH) + 1;
    localparam logic [LW-1:0] LDQ_FULL_OCC = LW'(LDQ_DEPTH);
    localparam logic [SW-1:0] STQ_FULL_OCC = SW'(STQ_DEPTH);

    // Pointers are {wrap, idx}; a plain +1 wraps correctly since DEPTH is a power of 2.
    logic [LW-1:0] ldq_head_r, ldq_tail_r;
    logic [SW-1:0] stq_head_r, stq_ret_r, stq_tail_r;

    logic [LW-1:0] ldq_head_nxt_s, ldq_tail_nxt_s, ldq_occ_s;
    logic [SW-1:0] stq_head_nxt_s, stq_ret_nxt_s, stq_tail_nxt_s, stq_occ_s;
    logic          ldq_empty_s, ldq_full_s, stq_full_s;
    logic          ldq_ret_ok_s, stq_ret_ok_s, stq_drn_ok_s;
    logic          ldq_alloc_s, stq_alloc_s;

    // Occupancy, request qualification and next-pointer selection.
    always_comb begin
        ldq_occ_s    = ldq_tail_r - ldq_head_r;
        stq_occ_s    = stq_tail_r - stq_head_r;
        ldq_empty_s  = (ldq_tail_r == ldq_head_r);
        ldq_full_s   = (ldq_occ_s == LDQ_FULL_OCC);
        stq_full_s   = (stq_occ_s == STQ_FULL_OCC);

        ldq_ret_ok_s = bus.ldq_retire_rb1 & ~ldq_empty_s;
        stq_ret_ok_s = bus.stq_retire_rb1 & (stq_ret_r != stq_tail_r);
        stq_drn_ok_s = bus.stq_drain_mm & (stq_head_r != stq_ret_r);

        // A same-cycle free lets a full queue accept the allocation.
        ldq_alloc_s  = bus.disp_valid_rs0 & bus.disp_is_ld_rs0 & (~ldq_full_s | ldq_ret_ok_s);
        stq_alloc_s  = bus.disp_valid_rs0 & bus.disp_is_st_rs0 & (~stq_full_s | stq_drn_ok_s);

        ldq_head_nxt_s = ldq_ret_ok_s ? ldq_head_r + LW'(1) : ldq_head_r;
        stq_ret_nxt_s  = stq_ret_ok_s ? stq_ret_r + SW'(1) : stq_ret_r;
        stq_head_nxt_s = stq_drn_ok_s ? stq_head_r + SW'(1) : stq_head_r;

        if (bus.nuke_rb1.valid) begin
            ldq_tail_nxt_s = ldq_head_nxt_s;
            stq_tail_nxt_s = stq_ret_nxt_s;
        end else begin
            ldq_tail_nxt_s = ldq_alloc_s ? ldq_tail_r + LW'(1) : ldq_tail_r;
            stq_tail_nxt_s = stq_alloc_s ? stq_tail_r + SW'(1) : stq_tail_r;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ldq_head_r <= '0;
            ldq_tail_r <= '0;
            stq_head_r <= '0;
            stq_ret_r  <= '0;
            stq_tail_r <= '0;
        end else begin
            ldq_head_r <= ldq_head_nxt_s;
            ldq_tail_r <= ldq_tail_nxt_s;
            stq_head_r <= stq_head_nxt_s;
            stq_ret_r  <= stq_ret_nxt_s;
            stq_tail_r <= stq_tail_nxt_s;
        end
    end

    assign bus.ldqid_alloc_rs0 = ldq_tail_r;
    assign bus.stqid_alloc_rs0 = stq_tail_r;

`ifdef MEMQ_ID_ALLOC_SKID_EN
    assign bus.ldq_stall_rs0 = (ldq_occ_s >= LW'(LDQ_DEPTH - 1));
    assign bus.stq_stall_rs0 = (stq_occ_s >= SW'(STQ_DEPTH - 1));
`else
    assign bus.ldq_stall_rs0 = ldq_full_s;
    assign bus.stq_stall_rs0 = stq_full_s;
`endif

`ifdef ASSERT
    memq_id_alloc_chk u_chk (
        .clk          (clk),
        .reset        (reset),
        .ldq_drop     (~bus.nuke_rb1.valid & bus.disp_valid_rs0 & bus.disp_is_ld_rs0 & ~ldq_alloc_s),
        .stq_drop     (~bus.nuke_rb1.valid & bus.disp_valid_rs0 & bus.disp_is_st_rs0 & ~stq_alloc_s),
        .ldq_ret_bad  (bus.ldq_retire_rb1 & ~ldq_ret_ok_s),
        .stq_ret_bad  (bus.stq_retire_rb1 & ~stq_ret_ok_s),
        .stq_drn_bad  (bus.stq_drain_mm & ~stq_drn_ok_s)
    );
`endif
endmodule

`ifdef ASSERT
// Flags protocol violations seen by the allocator.
module memq_id_alloc_chk (
    input logic clk,
    input logic reset,
    input logic ldq_drop,
    input logic stq_drop,
    input logic ldq_ret_bad,
    input logic stq_ret_bad,
    input logic stq_drn_bad
);
    // Immediate checks sampled each cycle outside reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_ldq_full:  assert (!ldq_drop)    else $error("load allocated while LDQ full");
            a_stq_full:  assert (!stq_drop)    else $error("store allocated while STQ full");
            a_ldq_ret:   assert (!ldq_ret_bad) else $error("load retire with empty LDQ");
            a_stq_ret:   assert (!stq_ret_bad) else $error("store retire with no unretired store");
            a_stq_drn:   assert (!stq_drn_bad) else $error("drain with no senior store");
        end
    end
endmodule
`endif
